// File: rtl/csa_mul_iter.sv
// csa_mul_iter -- iterative multiplier built around a carry-save accumulator.
//
// Operands are captured on the accept edge as unsigned magnitudes plus a
// result sign. Then PP_PER_CYCLE partial products are folded into a redundant
// sum/carry pair on each of N = WIDTH/PP_PER_CYCLE edges, using only 3:2
// compressors. A single carry-propagate add and an optional negation on the
// RESOLVE edge produce the product, which is held until the consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operands and mode are presented
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       multiplicand / multiplier, WIDTH bits
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  product is available (high only in DONE)
//   out_ready  consumer accepts the product
//   p          product, 2*WIDTH bits
module csa_mul_iter #(
  parameter int WIDTH        = 16,
  parameter int PP_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N  = WIDTH / PP_PER_CYCLE;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [WIDTH-1:0] W_ONE    = 1;
  localparam logic [PW-1:0]    PW_ONE   = 1;
  localparam logic [CW-1:0]    CNT_ONE  = 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);

  // Parameter sanity: refuse to elaborate a configuration we cannot build.
  generate
    if (WIDTH < 4) begin : g_bad_width
      $error("csa_mul_iter: WIDTH must be >= 4");
    end
    if (PP_PER_CYCLE < 1 || (WIDTH % PP_PER_CYCLE) != 0) begin : g_bad_pp
      $error("csa_mul_iter: PP_PER_CYCLE must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

  state_t state_reg, state_next;

  logic [PW-1:0]    a_sh_reg;   // magnitude of a, pre-shifted to the next bit index
  logic [WIDTH-1:0] b_sh_reg;   // magnitude of b, LSB is the next multiplier bit
  logic             neg_reg;    // result sign
  logic [PW-1:0]    sum_reg;
  logic [PW-1:0]    carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [PW-1:0]    p_reg;

  // Magnitudes at accept. The WIDTH-bit unsigned result of ~x+1 holds
  // 2^(WIDTH-1) exactly, so the most negative operand needs no extra bit.
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             neg_in;

  always_comb begin
    a_abs  = (is_signed && a[WIDTH-1]) ? (~a + W_ONE) : a;
    b_abs  = (is_signed && b[WIDTH-1]) ? (~b + W_ONE) : b;
    neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // Carry-save chain: each stage compresses (sum, carry, partial product)
  // into a new (sum, carry) pair. The bit shifted out of the top of the
  // carry is dropped; everything is modulo 2^PW and the true product fits.
  logic [PP_PER_CYCLE:0][PW-1:0]  s_chain;
  logic [PP_PER_CYCLE:0][PW-1:0]  c_chain;
  logic [PP_PER_CYCLE-1:0][PW-1:0] pp_vec;

  assign s_chain[0] = sum_reg;
  assign c_chain[0] = carry_reg;

  generate
    for (genvar gi = 0; gi < PP_PER_CYCLE; gi++) begin : g_csa
      assign pp_vec[gi]      = b_sh_reg[gi] ? (a_sh_reg << gi) : '0;
      assign s_chain[gi + 1] = s_chain[gi] ^ c_chain[gi] ^ pp_vec[gi];
      assign c_chain[gi + 1] = ((s_chain[gi] & c_chain[gi]) |
                                (s_chain[gi] & pp_vec[gi])  |
                                (c_chain[gi] & pp_vec[gi])) << 1;
    end
  endgenerate

  // Final resolution: the only carry-propagate adder in the block.
  logic [PW-1:0] total, result;

  always_comb begin
    total  = sum_reg + carry_reg;
    result = neg_reg ? (~total + PW_ONE) : total;  // -0 wraps to 0
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ACC;
      ACC:     if (cnt_reg == CNT_LAST) state_next = RESOLVE;
      RESOLVE: state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      neg_reg   <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= '0;
      cnt_reg   <= '0;
      p_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= {{WIDTH{1'b0}}, a_abs};
            b_sh_reg  <= b_abs;
            neg_reg   <= neg_in;
            sum_reg   <= '0;
            carry_reg <= '0;
            cnt_reg   <= '0;
          end
        end
        ACC: begin
          sum_reg   <= s_chain[PP_PER_CYCLE];
          carry_reg <= c_chain[PP_PER_CYCLE];
          a_sh_reg  <= a_sh_reg << PP_PER_CYCLE;
          b_sh_reg  <= b_sh_reg >> PP_PER_CYCLE;
          cnt_reg   <= cnt_reg + CNT_ONE;
        end
        RESOLVE: begin
          p_reg <= result;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign p         = p_reg;

endmodule
